// File: rtl/controle_turno.sv
// controle_turno: turn controller for the two-player naval-attack game.
// Latches both ship maps, alternates turns between A and B, validates
// each one-hot attack, accumulates sticky hits per player, counts shots
// and declares a winner (01 A, 10 B) or a draw (11).
module controle_turno #(
    parameter int WIDTH     = 5,
    parameter int MAX_SHOTS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] map_a,
    input  logic [WIDTH-1:0] map_b,
    input  logic [WIDTH-1:0] attack,
    input  logic             confirm,
    output logic             turn,
    output logic [WIDTH-1:0] hits_a,
    output logic [WIDTH-1:0] hits_b,
    output logic [3:0]       shots_a,
    output logic [3:0]       shots_b,
    output logic             hit_flag,
    output logic             err,
    output logic             busy,
    output logic             game_over,
    output logic [1:0]       winner
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_Q = 4'(MAX_SHOTS);

    state_t           state_q, state_d;
    logic             turn_q, turn_d;
    logic [WIDTH-1:0] map_a_q, map_a_d;
    logic [WIDTH-1:0] map_b_q, map_b_d;
    logic [WIDTH-1:0] atk_q, atk_d;
    logic [WIDTH-1:0] hits_a_q, hits_a_d;
    logic [WIDTH-1:0] hits_b_q, hits_b_d;
    logic [3:0]       shots_a_q, shots_a_d;
    logic [3:0]       shots_b_q, shots_b_d;
    logic             hit_flag_q, hit_flag_d;
    logic             err_q, err_d;
    logic [1:0]       winner_q, winner_d;

    // Evaluation datapath for the player whose turn it is: the opponent's
    // map is the target, the current player's hit vector is accumulated.
    logic             atk_onehot;
    logic [WIDTH-1:0] opp, cur, cur_upd;
    logic             new_hit;
    logic [3:0]       shots_cur, shots_inc;

    assign atk_onehot = (attack != '0) && ((attack & (attack - WIDTH'(1))) == '0);
    assign opp        = turn_q ? map_a_q : map_b_q;
    assign cur        = turn_q ? hits_b_q : hits_a_q;
    assign cur_upd    = cur | (atk_q & opp);
    assign new_hit    = |(atk_q & opp & ~cur);
    assign shots_cur  = turn_q ? shots_b_q : shots_a_q;
    // Saturate so the counters can never run past the shot budget.
    assign shots_inc  = (shots_cur >= MAX_Q) ? shots_cur : shots_cur + 4'd1;

    // Next-state and register-update logic; everything holds by default.
    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        map_a_d    = map_a_q;
        map_b_d    = map_b_q;
        atk_d      = atk_q;
        hits_a_d   = hits_a_q;
        hits_b_d   = hits_b_q;
        shots_a_d  = shots_a_q;
        shots_b_d  = shots_b_q;
        hit_flag_d = hit_flag_q;
        winner_d   = winner_q;
        err_d      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                map_a_d = map_a;
                map_b_d = map_b;
                if (map_a == '0 && map_b == '0) begin
                    state_d  = ST_DONE;
                    winner_d = 2'b11;
                end else if (map_a == '0) begin
                    state_d  = ST_DONE;
                    winner_d = 2'b10;
                end else if (map_b == '0) begin
                    state_d  = ST_DONE;
                    winner_d = 2'b01;
                end else begin
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (confirm) begin
                    if (atk_onehot) begin
                        atk_d   = attack;
                        state_d = ST_EVAL;
                    end else if (!err_q) begin
                        // A held invalid request re-arms only after the
                        // pulse drops, giving one pulse every other cycle.
                        err_d = 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                hit_flag_d = new_hit;
                if (turn_q) begin
                    hits_b_d  = cur_upd;
                    shots_b_d = shots_inc;
                end else begin
                    hits_a_d  = cur_upd;
                    shots_a_d = shots_inc;
                end
                if (cur_upd == opp) begin
                    state_d  = ST_DONE;
                    winner_d = turn_q ? 2'b10 : 2'b01;
                end else if (turn_q && shots_inc == MAX_Q) begin
                    // A always opens, so B's last shot ends the game.
                    state_d  = ST_DONE;
                    winner_d = 2'b11;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State register; reset discards any in-flight attack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_LOAD;
            turn_q     <= 1'b0;
            map_a_q    <= '0;
            map_b_q    <= '0;
            atk_q      <= '0;
            hits_a_q   <= '0;
            hits_b_q   <= '0;
            shots_a_q  <= '0;
            shots_b_q  <= '0;
            hit_flag_q <= 1'b0;
            err_q      <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            map_a_q    <= map_a_d;
            map_b_q    <= map_b_d;
            atk_q      <= atk_d;
            hits_a_q   <= hits_a_d;
            hits_b_q   <= hits_b_d;
            shots_a_q  <= shots_a_d;
            shots_b_q  <= shots_b_d;
            hit_flag_q <= hit_flag_d;
            err_q      <= err_d;
            winner_q   <= winner_d;
        end
    end

    assign turn      = turn_q;
    assign hits_a    = hits_a_q;
    assign hits_b    = hits_b_q;
    assign shots_a   = shots_a_q;
    assign shots_b   = shots_b_q;
    assign hit_flag  = hit_flag_q;
    assign err       = err_q;
    assign winner    = winner_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_EVAL);
    assign game_over = (state_q == ST_DONE);

endmodule

// File: tb/tb_controle_turno.sv
// Directed bench for controle_turno with MAX_SHOTS = 8,
// map_a = 00011, map_b = 10100 unless a corner case needs otherwise.
module tb_controle_turno;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] map_a, map_b, attack;
    logic         confirm;
    logic         turn, hit_flag, err, busy, game_over;
    logic [W-1:0] hits_a, hits_b;
    logic [3:0]   shots_a, shots_b;
    logic [1:0]   winner;

    int vectors = 0;
    int miscompares = 0;

    controle_turno #(.WIDTH(W), .MAX_SHOTS(8)) dut (
        .clk(clk), .rstn(rstn), .map_a(map_a), .map_b(map_b),
        .attack(attack), .confirm(confirm), .turn(turn),
        .hits_a(hits_a), .hits_b(hits_b), .shots_a(shots_a),
        .shots_b(shots_b), .hit_flag(hit_flag), .err(err), .busy(busy),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reset with the given maps, release in the LOAD cycle, then take LOAD
    task automatic do_reset(input logic [W-1:0] ma, input logic [W-1:0] mb);
        rstn = 1'b0; confirm = 1'b0; attack = '0; map_a = ma; map_b = mb;
        step();
        step();
        rstn = 1'b1;
    endtask

    // one full turn: request sampled at edge k, results visible after k+1
    task automatic play(input logic [W-1:0] v);
        attack = v; confirm = 1'b1;
        step();
        confirm = 1'b0;
        step();
    endtask

    initial begin
        // 1: reset values and LOAD
        do_reset(5'b00011, 5'b10100);
        chk("rst_turn", turn, 0);
        chk("rst_hits_a", hits_a, 0);
        chk("rst_hits_b", hits_b, 0);
        chk("rst_shots_a", shots_a, 0);
        chk("rst_shots_b", shots_b, 0);
        chk("rst_winner", winner, 0);
        chk("rst_flags", {hit_flag, err, game_over}, 0);
        chk("load_busy", busy, 1);
        step();
        chk("wait_busy", busy, 0);
        chk("wait_over", game_over, 0);

        // 2: A hits 00100, B hits 00001
        attack = 5'b00100; confirm = 1'b1;
        step();
        chk("eval_busy", busy, 1);
        confirm = 1'b0;
        step();
        chk("a1_hits_a", hits_a, 5'b00100);
        chk("a1_shots_a", shots_a, 1);
        chk("a1_hit_flag", hit_flag, 1);
        chk("a1_turn", turn, 1);
        chk("a1_busy", busy, 0);
        play(5'b00001);
        chk("b1_hits_b", hits_b, 5'b00001);
        chk("b1_shots_b", shots_b, 1);
        chk("b1_turn", turn, 0);

        // 3: invalid attack held high pulses err every other cycle
        attack = 5'b00110; confirm = 1'b1;
        step();
        chk("inv_err1", err, 1);
        step();
        chk("inv_err_clr", err, 0);
        step();
        chk("inv_err2", err, 1);
        confirm = 1'b0;
        step();
        chk("inv_err_end", err, 0);
        chk("inv_state", {turn, shots_a, shots_b, hits_a, hits_b}, {1'b0, 4'd1, 4'd1, 5'b00100, 5'b00001});
        attack = 5'b00000; confirm = 1'b1;
        step();
        confirm = 1'b0;
        chk("zero_err", err, 1);
        // repeat attack on an already-hit cell consumes a shot
        step();
        play(5'b00100);
        chk("rep_hit_flag", hit_flag, 0);
        chk("rep_shots_a", shots_a, 2);
        chk("rep_hits_a", hits_a, 5'b00100);
        chk("rep_turn", turn, 1);
        // B sinks all of A's ships
        play(5'b00010);
        chk("bwin_hits_b", hits_b, 5'b00011);
        chk("bwin_winner", winner, 2'b10);
        chk("bwin_over", game_over, 1);
        chk("bwin_turn", turn, 1);

        // 4: A 00100, B 01000, A 10000 -> A wins
        do_reset(5'b00011, 5'b10100);
        step();
        play(5'b00100);
        play(5'b01000);
        chk("bmiss_flag", hit_flag, 0);
        play(5'b10000);
        chk("awin_hits_a", hits_a, 5'b10100);
        chk("awin_winner", winner, 2'b01);
        chk("awin_over", game_over, 1);
        chk("awin_turn", turn, 0);
        chk("awin_busy", busy, 0);
        play(5'b01000);
        step();
        chk("done_frozen", {turn, shots_a, shots_b, hits_a, hits_b, winner, game_over},
            {1'b0, 4'd2, 4'd1, 5'b10100, 5'b00000, 2'b01, 1'b1});

        // held confirm through EVAL fires the next player's turn, not a repeat
        do_reset(5'b00011, 5'b10100);
        step();
        attack = 5'b01000; confirm = 1'b1;
        step();
        step();
        chk("hold_a_shot", {shots_a, shots_b, turn}, {4'd1, 4'd0, 1'b1});
        step();
        chk("hold_b_eval", busy, 1);
        step();
        chk("hold_b_shot", {shots_a, shots_b, turn}, {4'd1, 4'd1, 1'b0});
        confirm = 1'b0;

        // 5: all misses -> draw after B's 8th shot
        do_reset(5'b00011, 5'b10100);
        step();
        for (int i = 0; i < 7; i++) begin
            play(5'b01000);
            play(5'b00100);
        end
        chk("miss7_over", game_over, 0);
        play(5'b01000);
        chk("miss_a8", {shots_a, game_over}, {4'd8, 1'b0});
        play(5'b00100);
        chk("draw_shots", {shots_a, shots_b}, {4'd8, 4'd8});
        chk("draw_winner", winner, 2'b11);
        chk("draw_over", game_over, 1);

        // 6: empty maps at LOAD
        do_reset(5'b00011, 5'b00000);
        step();
        chk("mapb0", {game_over, winner, busy}, {1'b1, 2'b01, 1'b0});
        do_reset(5'b00000, 5'b10100);
        step();
        chk("mapa0", {game_over, winner}, {1'b1, 2'b10});
        do_reset(5'b00000, 5'b00000);
        step();
        chk("maps0", {game_over, winner}, {1'b1, 2'b11});

        // reset pulsed mid-EVAL discards the attack
        do_reset(5'b00011, 5'b10100);
        step();
        attack = 5'b00100; confirm = 1'b1;
        step();
        confirm = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst", {busy, turn, shots_a, hits_a, hit_flag, game_over, winner},
            {1'b1, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 2'b00});
        step();
        rstn = 1'b1;
        step();
        step();
        chk("mid_rst_after", {busy, turn, shots_a, hits_a, game_over}, {1'b0, 1'b0, 4'd0, 5'b00000, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
